uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO plus launch sequencer between game-side message producers and uart_tx.
- Producers push one byte per cycle; the queue replays bytes to uart_tx one at a time. No byte is lost while uart_tx is busy.
- Producers are the mole-position ASCII '0'..'4', game-over 'R' and future score reports.
- Replaces direct tx_start driving from top-level logic. Single clock domain: the 100 MHz system clock.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ADDR_BITS, 3, log2(DEPTH).
- BUSY_WAIT, 4, cycles after tx_start within which tx_busy must assert before the byte is treated as accepted anyway (1..15).

Ports:
- clock  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low
- push_valid  input  1  producer offers push_data this cycle
- push_data  input  8  byte to enqueue
- push_ready  output  1  high when FIFO not full; push accepted when push_valid && push_ready
- flush  input  1  synchronous clear of queued, not-yet-launched bytes
- tx_busy  input  1  busy flag from uart_tx
- tx_start  output  1  one-cycle launch pulse to uart_tx
- tx_data  output  8  byte presented to uart_tx; held stable until next launch
- count  output  ADDR_BITS+1  bytes queued, excluding any byte in flight
- empty  output  1  count == 0
- overflow  output  1  one-cycle pulse when push_valid is high while full (byte dropped)

Behaviour:
- Reset (async, active-low) values:
  - tx_start=0, tx_data=8'h00, count=0, empty=1, push_ready=1, overflow=0.
  - Read/write pointers 0; FSM in IDLE; BUSY_WAIT counter 0.
- Storage: circular buffer with pointers of ADDR_BITS bits that wrap DEPTH-1 -> 0. Occupancy counter is ADDR_BITS+1 bits.
- full = (count == DEPTH). push_ready = !full, driven from registered state only; no combinational path from pop.
- Push: on accept, write mem[wr_ptr], wr_ptr+1, count+1.
- Push while full: dropped, no state change, overflow=1 for that cycle.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Pop when full: push_ready was 0 that cycle, so a concurrent push is dropped and flagged overflow.
- FSM states:
  - IDLE: if !empty && !tx_busy, then next cycle tx_data<=mem[rd_ptr], rd_ptr+1, count-1, tx_start=1, clear wait counter, go LAUNCH. Otherwise stay.
  - LAUNCH: tx_start=0. If tx_busy=1, go DRAIN. Else increment wait counter; when it reaches BUSY_WAIT, go IDLE (byte treated as consumed, no retry).
  - DRAIN: stay while tx_busy=1; on tx_busy=0 go IDLE.
- Latency:
  - First push into an empty queue with tx_busy=0: push at cycle N, tx_start high at cycle N+2 (N+1 count update, N+2 launch).
  - Minimum spacing between tx_start pulses is the UART frame time plus 2 cycles.
- tx_start is never asserted in any state other than the single IDLE->LAUNCH transition cycle. It is never high two consecutive cycles.
- flush:
  - Sets rd_ptr=wr_ptr and count=0 in one cycle.
  - Does not abort the byte in flight; FSM continues LAUNCH/DRAIN normally.
  - flush has priority over a same-cycle push: that push is discarded without an overflow pulse.
  - flush and an IDLE launch in the same cycle: the launch is suppressed.
- Reset mid-frame: queue and FSM clear immediately. uart_tx is reset by the same signal, so no partial-state handshake is needed.
- tx_busy already high when a byte is queued in IDLE: wait in IDLE; launch on the first cycle tx_busy is low.

Optional Feature:
- Macro UART_TXQ_PRIORITY_EN.
- When defined:
  - Adds input ports prio_valid (1) and prio_data (8), plus a single-entry priority holding register.
  - prio_valid loads the register; a second prio_valid while it is occupied overwrites it.
  - In IDLE, an occupied priority register launches before the FIFO head. The FIFO is untouched and count is unaffected.
  - flush also clears the priority register.
  - Intended for 'R' game-over, so it is not stuck behind stale mole bytes.
- When undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset release, push '2' (8'h32) with tx_busy=0 -> tx_start single pulse 2 cycles after push, tx_data=8'h32, count returns to 0, empty=1.
- Push 8 bytes 8'h30..8'h37 back-to-back with a bench UART model (busy 1 cycle after start, 20 cycles long) -> exactly 8 tx_start pulses, data in order 30..37, no pulse while tx_busy=1.
- Fill to 8 with tx_busy held 1, push 8'h52 -> push_ready=0, overflow pulse 1 cycle, count stays 8. Release tx_busy -> 8'h30 sent first, 8'h52 never sent.
- tx_busy never asserts after tx_start, BUSY_WAIT=4 -> FSM back to IDLE after 4 cycles, next queued byte launched. No retry of the first byte.
- Queue 3 bytes, launch first, assert flush during DRAIN -> count=0 next cycle, first byte completes, no further tx_start.
- With UART_TXQ_PRIORITY_EN: FIFO holds 30,31; tx_busy=1; prio_valid with 8'h52 -> after busy drops, send order 52,30,31.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch sequencer feeding uart_tx.
//
// Producers push one byte per cycle. The sequencer hands bytes to uart_tx
// one at a time and waits out each frame, so no byte is lost while the
// transmitter is busy.
//
// Ports:
//   clock       system clock (100 MHz)
//   reset       asynchronous, active-low
//   push_valid  producer offers push_data this cycle
//   push_data   byte to enqueue
//   push_ready  FIFO not full (derived from registered count only)
//   flush       synchronous clear of queued, not-yet-launched bytes
//   tx_busy     busy flag from uart_tx
//   tx_start    one-cycle launch pulse to uart_tx
//   tx_data     byte presented to uart_tx, held until the next launch
//   count       bytes queued, excluding any byte in flight
//   empty       count == 0
//   overflow    pulse when push_valid is high while full (byte dropped)
//
// Optional feature, macro UART_TXQ_PRIORITY_EN:
//   prio_valid / prio_data load a single-entry priority register. When it
//   is occupied, it launches ahead of the FIFO head without touching the
//   FIFO. flush also clears it.
module uart_tx_queue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3,
  parameter int BUSY_WAIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic [7:0]           push_data,
  output logic                 push_ready,
  input  logic                 flush,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 empty,
`ifdef UART_TXQ_PRIORITY_EN
  input  logic                 prio_valid,
  input  logic [7:0]           prio_data,
`endif
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN
  } state_t;

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [3:0]         WAIT_LIMIT = 4'(BUSY_WAIT);

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [3:0]           wait_cnt;
  state_t               state;

  logic full;
  logic push_acc;
  logic launch_fifo;
  logic launch_ok;

  assign full       = (count == FULL_COUNT);
  assign push_ready = !full;
  assign empty      = (count == '0);
  // flush swallows a same-cycle push silently, so it also masks overflow.
  assign overflow   = push_valid && full && !flush;
  assign push_acc   = push_valid && !full && !flush;
  assign launch_ok  = (state == IDLE) && !tx_busy && !flush;

`ifdef UART_TXQ_PRIORITY_EN
  logic       prio_occ;
  logic [7:0] prio_reg;
  logic       launch_prio;

  assign launch_prio = launch_ok && prio_occ;
  assign launch_fifo = launch_ok && !prio_occ && !empty;

  // A new prio_valid in the same cycle as a priority launch keeps the
  // register occupied with the fresh byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio_occ <= 1'b0;
      prio_reg <= '0;
    end else if (flush) begin
      prio_occ <= 1'b0;
    end else if (prio_valid) begin
      prio_occ <= 1'b1;
      prio_reg <= prio_data;
    end else if (launch_prio) begin
      prio_occ <= 1'b0;
    end
  end
`else
  assign launch_fifo = launch_ok && !empty;
`endif

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch_fifo) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, launch_fifo})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      wait_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
`ifdef UART_TXQ_PRIORITY_EN
          if (launch_prio) begin
            tx_data  <= prio_reg;
            tx_start <= 1'b1;
            wait_cnt <= '0;
            state    <= LAUNCH;
          end else
`endif
          if (launch_fifo) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            wait_cnt <= '0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            state <= DRAIN;
          end else begin
            // No busy response: give up after BUSY_WAIT cycles and treat
            // the byte as consumed.
            wait_cnt <= wait_cnt + 1'b1;
            if ((wait_cnt + 4'd1) == WAIT_LIMIT) begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = '0;
  logic       push_ready;
  logic       flush = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] count;
  logic       empty;
  logic       overflow;
`ifdef UART_TXQ_PRIORITY_EN
  logic       prio_valid = 1'b0;
  logic [7:0] prio_data = '0;
`endif

  uart_tx_queue #(.DEPTH(8), .ADDR_BITS(3), .BUSY_WAIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .flush      (flush),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .count      (count),
    .empty      (empty),
`ifdef UART_TXQ_PRIORITY_EN
    .prio_valid (prio_valid),
    .prio_data  (prio_data),
`endif
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [7:0]  sb [$];
  int unsigned n_starts = 0;
  int unsigned cyc = 0;
  int unsigned start_prev = 0;
  int unsigned start_last = 0;
  logic        prev_start = 1'b0;

  // Simple uart_tx model: busy starts the cycle after tx_start, lasts 20.
  logic       busy_hold = 1'b0;
  logic       uart_dead = 1'b0;
  int unsigned busy_cnt = 0;
  assign tx_busy = busy_hold || (busy_cnt != 0);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (tx_start && !uart_dead) busy_cnt <= 20;
    else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && tx_start) begin
      n_starts++;
      start_prev = start_last;
      start_last = cyc;
      check("start_gap", {31'd0, prev_start}, 0);
      check("start_while_busy", {31'd0, tx_busy}, 0);
      check("start_expected", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
    end
    prev_start = tx_start;
  end

  task automatic push_seq(input logic [7:0] base, input int unsigned n, input bit expect_sent);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
      push_valid = 1'b1;
      push_data  = base + 8'(i);
      if (expect_sent) sb.push_back(push_data);
    end
    @(posedge clock); #1;
    push_valid = 1'b0;
  endtask

  task automatic settle();
    int unsigned quiet = 0;
    for (int unsigned i = 0; i < 3000 && quiet < 40; i++) begin
      @(negedge clock);
      if (empty && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    check("settle", {31'd0, quiet >= 40}, 1);
  endtask

  int unsigned s0;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_count", {28'd0, count}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_push_ready", {31'd0, push_ready}, 1);
    check("rst_overflow", {31'd0, overflow}, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Single byte latency: push at N, count at N+1, launch at N+2.
    @(posedge clock); #1;
    push_valid = 1'b1; push_data = 8'h32; sb.push_back(8'h32);
    @(negedge clock);
    check("lat_n_start", {31'd0, tx_start}, 0);
    @(posedge clock); #1 push_valid = 1'b0;
    @(negedge clock);
    check("lat_n1_count", {28'd0, count}, 1);
    check("lat_n1_start", {31'd0, tx_start}, 0);
    @(negedge clock);
    check("lat_n2_start", {31'd0, tx_start}, 1);
    check("lat_n2_count", {28'd0, count}, 0);
    settle();
    check("single_empty", {31'd0, empty}, 1);
    check("single_starts", n_starts, 1);

    // Burst of eight while the UART model paces launches.
    s0 = n_starts;
    push_seq(8'h30, 8, 1'b1);
    settle();
    check("burst_starts", n_starts - s0, 8);
    check("burst_sb_left", sb.size(), 0);

    // Fill while busy, then overflow.
    busy_hold = 1'b1;
    push_seq(8'h30, 8, 1'b1);
    @(negedge clock);
    check("full_count", {28'd0, count}, 8);
    check("full_ready", {31'd0, push_ready}, 0);
    @(posedge clock); #1 push_valid = 1'b1; push_data = 8'h52;
    @(negedge clock);
    check("ovf_pulse", {31'd0, overflow}, 1);
    @(posedge clock); #1 push_valid = 1'b0;
    @(negedge clock);
    check("ovf_clear", {31'd0, overflow}, 0);
    check("ovf_count", {28'd0, count}, 8);
    @(posedge clock); #1 busy_hold = 1'b0;
    settle();
    check("ovf_sb_left", sb.size(), 0);

    // UART never answers: BUSY_WAIT timeout, next byte 5 cycles later.
    uart_dead = 1'b1;
    s0 = n_starts;
    push_seq(8'h41, 2, 1'b1);
    settle();
    check("dead_starts", n_starts - s0, 2);
    check("dead_spacing", start_last - start_prev, 5);
    uart_dead = 1'b0;

    // Flush during DRAIN: in-flight byte finishes, queued ones vanish.
    s0 = n_starts;
    sb.push_back(8'h61);
    push_seq(8'h61, 3, 1'b0);
    for (int unsigned i = 0; i < 100 && !tx_busy; i++) @(negedge clock);
    check("drain_seen", {31'd0, tx_busy}, 1);
    @(posedge clock); #1 flush = 1'b1; push_valid = 1'b1; push_data = 8'h99;
    @(negedge clock);
    check("flush_no_ovf", {31'd0, overflow}, 0);
    @(posedge clock); #1 flush = 1'b0; push_valid = 1'b0;
    @(negedge clock);
    check("flush_count", {28'd0, count}, 0);
    check("flush_empty", {31'd0, empty}, 1);
    settle();
    check("flush_starts", n_starts - s0, 1);
    check("flush_sb_left", sb.size(), 0);

`ifdef UART_TXQ_PRIORITY_EN
    // Priority byte jumps the queue.
    s0 = n_starts;
    busy_hold = 1'b1;
    push_seq(8'h30, 2, 1'b0);
    @(posedge clock); #1 prio_valid = 1'b1; prio_data = 8'h52;
    @(posedge clock); #1 prio_valid = 1'b0;
    sb.push_back(8'h52); sb.push_back(8'h30); sb.push_back(8'h31);
    @(negedge clock);
    check("prio_count", {28'd0, count}, 2);
    @(posedge clock); #1 busy_hold = 1'b0;
    settle();
    check("prio_starts", n_starts - s0, 3);
    check("prio_sb_left", sb.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
